// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Hazard and stall controller for the five-stage MIPS pipeline with the
//   attached AES coprocessor. It works beside the forwarding unit and handles
//   the cases that forwarding cannot resolve:
//     - load-use hazards;
//     - branch or jump-register operands that are not yet produced.
//   It also runs the multi-cycle AES instruction through an
//   IDLE -> ISSUE -> WAIT -> DRAIN sequence, with a timeout on WAIT.
//
// Parameters:
//   AES_TIMEOUT  maximum number of WAIT cycles before the op is aborted (2..255)
//   CNT_W        width of the WAIT counter (2**CNT_W must exceed AES_TIMEOUT)
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   IfIdRegRs/IfIdRegRt            source registers of the instruction in ID
//   IdExRegRt/IdExRegDst           load target / final destination in EX
//   IdExMemRead/IdExRegWrite       EX instruction is a load / writes a register
//   ExMemRegRd/ExMemMemRead        destination of MEM instruction / it is a load
//   Branch/JumpReg/AesReq          ID instruction class
//   AesDone                        coprocessor completion pulse
//   PCWrite/IfIdWrite/IdExFlush    pipeline hold and bubble controls
//   AesGo                          registered one-cycle start pulse
//   AesBusy                        AES sequence in ISSUE or WAIT
//   AesErr                         sticky timeout flag
//   StallCycles                    saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int AES_TIMEOUT = 64,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  IfIdRegRs,
   input  logic [4:0]  IfIdRegRt,
   input  logic [4:0]  IdExRegRt,
   input  logic [4:0]  IdExRegDst,
   input  logic        IdExMemRead,
   input  logic        IdExRegWrite,
   input  logic [4:0]  ExMemRegRd,
   input  logic        ExMemMemRead,
   input  logic        Branch,
   input  logic        JumpReg,
   input  logic        AesReq,
   input  logic        AesDone,
   output logic        PCWrite,
   output logic        IfIdWrite,
   output logic        IdExFlush,
   output logic        AesGo,
   output logic        AesBusy,
   output logic        AesErr,
   output logic [15:0] StallCycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } aesState_t;

   // Counter value seen in the last permitted WAIT cycle.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(AES_TIMEOUT - 1);

   aesState_t        stateReg, stateNext;
   logic [CNT_W-1:0] waitCntReg, waitCntNext;
   logic             aesGoReg, aesGoNext;
   logic             aesErrReg, aesErrNext;
   logic [15:0]      stallCntReg, stallCntNext;

   logic branchOrJr;
   logic exMatch, memMatch;
   logic loadUse, brEx, brMem, hz;
   logic aesStall, stall;

   // ---------------------------------------------------------------------------
   // Hazard detection. Register 0 is hard-wired, so it never creates a hazard.
   // A jump-register only reads rs; a branch compares rs and rt.
   // ---------------------------------------------------------------------------
   always_comb begin
      branchOrJr = Branch || JumpReg;
      exMatch    = (IdExRegDst == IfIdRegRs) || (Branch && (IdExRegDst == IfIdRegRt));
      memMatch   = (ExMemRegRd == IfIdRegRs) || (Branch && (ExMemRegRd == IfIdRegRt));

      loadUse = IdExMemRead && (IdExRegRt != 5'd0) &&
                ((IdExRegRt == IfIdRegRs) || (IdExRegRt == IfIdRegRt));
      // Operand still being computed in EX (ALU result or load address).
      brEx    = branchOrJr && IdExRegWrite && (IdExRegDst != 5'd0) && exMatch;
      // Load data not available until after MEM; forwarding cannot reach ID.
      brMem   = branchOrJr && ExMemMemRead && (ExMemRegRd != 5'd0) && memMatch;
      hz      = loadUse || brEx || brMem;

      // DRAIN deliberately contributes nothing so the AES op can leave ID.
      aesStall = (stateReg == ISSUE) || (stateReg == WAIT) ||
                 ((stateReg == IDLE) && AesReq);
      stall    = hz || aesStall;
   end

   assign PCWrite     = ~stall;
   assign IfIdWrite   = ~stall;
   assign IdExFlush   = stall;
   assign AesGo       = aesGoReg;
   assign AesBusy     = (stateReg == ISSUE) || (stateReg == WAIT);
   assign AesErr      = aesErrReg;
   assign StallCycles = stallCntReg;

   // ---------------------------------------------------------------------------
   // AES sequencing: next state, wait counter and error flag.
   // ---------------------------------------------------------------------------
   always_comb begin
      stateNext   = stateReg;
      waitCntNext = waitCntReg;
      aesErrNext  = aesErrReg;

      unique case (stateReg)
         IDLE: begin
            // Operands must be ready before the coprocessor is started.
            if (AesReq && !hz) begin
               stateNext = ISSUE;
            end
         end
         ISSUE: begin
            waitCntNext = '0;
            stateNext   = WAIT;
         end
         WAIT: begin
            waitCntNext = waitCntReg + CNT_W'(1);
            // A completion arriving in the timeout cycle wins; no error.
            if (AesDone) begin
               stateNext = DRAIN;
            end else if (waitCntReg == TIMEOUT_LAST) begin
               stateNext  = DRAIN;
               aesErrNext = 1'b1;
            end
         end
         DRAIN: begin
            // AesReq is ignored here: it still belongs to the op just finished.
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      // The start pulse is registered, so it lines up with the ISSUE cycle.
      aesGoNext = (stateNext == ISSUE) && (stateReg == IDLE);

      stallCntNext = stallCntReg;
      if (stall && (stallCntReg != 16'hFFFF)) begin
         stallCntNext = stallCntReg + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg    <= IDLE;
         waitCntReg  <= '0;
         aesGoReg    <= 1'b0;
         aesErrReg   <= 1'b0;
         stallCntReg <= 16'd0;
      end else begin
         stateReg    <= stateNext;
         waitCntReg  <= waitCntNext;
         aesGoReg    <= aesGoNext;
         aesErrReg   <= aesErrNext;
         stallCntReg <= stallCntNext;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed bench for hazard_stall_ctrl. Two instances share the stimulus:
// dut uses the default timeout, dutT uses AES_TIMEOUT=4 with a 3-bit counter
// for the timeout and done-versus-timeout cases. Inputs change on the falling
// edge, and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  IfIdRegRs, IfIdRegRt, IdExRegRt, IdExRegDst, ExMemRegRd;
   logic        IdExMemRead, IdExRegWrite, ExMemMemRead;
   logic        Branch, JumpReg, AesReq, AesDone;

   logic        PCWrite, IfIdWrite, IdExFlush, AesGo, AesBusy, AesErr;
   logic [15:0] StallCycles;
   logic        PCWriteT, IfIdWriteT, IdExFlushT, AesGoT, AesBusyT, AesErrT;
   logic [15:0] StallCyclesT;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .reset(reset),
      .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt),
      .IdExRegRt(IdExRegRt), .IdExRegDst(IdExRegDst),
      .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite),
      .ExMemRegRd(ExMemRegRd), .ExMemMemRead(ExMemMemRead),
      .Branch(Branch), .JumpReg(JumpReg),
      .AesReq(AesReq), .AesDone(AesDone),
      .PCWrite(PCWrite), .IfIdWrite(IfIdWrite), .IdExFlush(IdExFlush),
      .AesGo(AesGo), .AesBusy(AesBusy), .AesErr(AesErr),
      .StallCycles(StallCycles)
   );

   hazard_stall_ctrl #(.AES_TIMEOUT(4), .CNT_W(3)) dutT (
      .clk(clk), .reset(reset),
      .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt),
      .IdExRegRt(IdExRegRt), .IdExRegDst(IdExRegDst),
      .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite),
      .ExMemRegRd(ExMemRegRd), .ExMemMemRead(ExMemMemRead),
      .Branch(Branch), .JumpReg(JumpReg),
      .AesReq(AesReq), .AesDone(AesDone),
      .PCWrite(PCWriteT), .IfIdWrite(IfIdWriteT), .IdExFlush(IdExFlushT),
      .AesGo(AesGoT), .AesBusy(AesBusyT), .AesErr(AesErrT),
      .StallCycles(StallCyclesT)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic clearIn();
      IfIdRegRs = 5'd0; IfIdRegRt = 5'd0; IdExRegRt = 5'd0; IdExRegDst = 5'd0;
      ExMemRegRd = 5'd0; IdExMemRead = 1'b0; IdExRegWrite = 1'b0;
      ExMemMemRead = 1'b0; Branch = 1'b0; JumpReg = 1'b0;
      AesReq = 1'b0; AesDone = 1'b0;
   endtask

   task automatic pulseReset();
      @(negedge clk); clearIn(); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   initial begin
      clearIn();
      #2 reset = 1'b1;
      #1;
      checkVal("rst_pcw",   PCWrite, 1);
      checkVal("rst_ifid",  IfIdWrite, 1);
      checkVal("rst_flush", IdExFlush, 0);
      checkVal("rst_go",    AesGo, 0);
      checkVal("rst_busy",  AesBusy, 0);
      checkVal("rst_err",   AesErr, 0);
      checkVal("rst_stall", StallCycles, 0);
      @(negedge clk); reset = 1'b0;

      // lw $5 in EX, ID uses rs=5
      @(negedge clk); IdExMemRead = 1; IdExRegRt = 5; IfIdRegRs = 5; IfIdRegRt = 2; #1;
      checkVal("lu_pcw",   PCWrite, 0);
      checkVal("lu_ifid",  IfIdWrite, 0);
      checkVal("lu_flush", IdExFlush, 1);
      @(negedge clk); clearIn(); #1;
      checkVal("lu_rel_pcw",   PCWrite, 1);
      checkVal("lu_rel_flush", IdExFlush, 0);
      checkVal("lu_cnt",       StallCycles, 1);

      // lw $0 never hazards
      @(negedge clk); IdExMemRead = 1; IdExRegRt = 0; IfIdRegRs = 0; #1;
      checkVal("lu0_pcw", PCWrite, 1);
      @(negedge clk); clearIn(); #1;
      checkVal("lu0_cnt", StallCycles, 1);

      // lw $7 then beq $7,$3: BR_EX (with LU) then BR_MEM, release on 3rd
      @(negedge clk); Branch = 1; IfIdRegRs = 7; IfIdRegRt = 3;
      IdExMemRead = 1; IdExRegWrite = 1; IdExRegRt = 7; IdExRegDst = 7; #1;
      checkVal("brld_c1_pcw", PCWrite, 0);
      @(negedge clk); IdExMemRead = 0; IdExRegWrite = 0; IdExRegRt = 0; IdExRegDst = 0;
      ExMemMemRead = 1; ExMemRegRd = 7; #1;
      checkVal("brld_c2_pcw", PCWrite, 0);
      @(negedge clk); ExMemMemRead = 0; #1;
      checkVal("brld_c3_pcw", PCWrite, 1);
      checkVal("brld_cnt",    StallCycles, 3);

      // add $7 then jr $7: exactly one stall
      @(negedge clk); clearIn(); JumpReg = 1; IfIdRegRs = 7; IdExRegWrite = 1; IdExRegDst = 7; #1;
      checkVal("jr_c1_pcw", PCWrite, 0);
      @(negedge clk); IdExRegWrite = 0; IdExRegDst = 0; ExMemRegRd = 7; #1;
      checkVal("jr_c2_pcw", PCWrite, 1);
      checkVal("jr_cnt",    StallCycles, 4);

      // jr only reads rs: an rt match is not a hazard
      @(negedge clk); clearIn(); JumpReg = 1; IfIdRegRs = 2; IfIdRegRt = 7;
      IdExRegWrite = 1; IdExRegDst = 7; #1;
      checkVal("jr_rt_pcw", PCWrite, 1);
      // destination $0 never hazards
      @(negedge clk); clearIn(); Branch = 1; IdExRegWrite = 1; IdExRegDst = 0; #1;
      checkVal("br_r0_pcw", PCWrite, 1);
      // beq matches on rt
      @(negedge clk); clearIn(); Branch = 1; IfIdRegRs = 2; IfIdRegRt = 9;
      IdExRegWrite = 1; IdExRegDst = 9; #1;
      checkVal("br_rt_pcw", PCWrite, 0);
      // plain ALU consumer is left to forwarding
      @(negedge clk); clearIn(); IfIdRegRs = 9; IdExRegWrite = 1; IdExRegDst = 9; #1;
      checkVal("alu_fwd_pcw", PCWrite, 1);
      checkVal("alu_fwd_cnt", StallCycles, 5);

      // AES op, done pulsed 5 cycles after AesGo
      @(negedge clk); clearIn(); AesReq = 1; #1;
      checkVal("aes_idle_pcw",  PCWrite, 0);
      checkVal("aes_idle_go",   AesGo, 0);
      checkVal("aes_idle_busy", AesBusy, 0);
      @(negedge clk); #1;
      checkVal("aes_issue_go",   AesGo, 1);
      checkVal("aes_issue_busy", AesBusy, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checkVal($sformatf("aes_wait%0d_go", i),   AesGo, 0);
         checkVal($sformatf("aes_wait%0d_busy", i), AesBusy, 1);
      end
      @(negedge clk); AesDone = 1; #1;
      checkVal("aes_done_busy", AesBusy, 1);
      checkVal("aes_done_pcw",  PCWrite, 0);
      @(negedge clk); AesDone = 0; #1;
      checkVal("aes_drain_pcw",  PCWrite, 1);
      checkVal("aes_drain_busy", AesBusy, 0);
      @(negedge clk); AesReq = 0; #1;
      checkVal("aes_post_go",  AesGo, 0);
      checkVal("aes_post_err", AesErr, 0);
      checkVal("aes_post_cnt", StallCycles, 12);

      // Timeout, AES_TIMEOUT=4
      pulseReset();
      @(negedge clk); AesReq = 1; #1;
      @(negedge clk); #1;
      checkVal("to_issue_go", AesGoT, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checkVal($sformatf("to_wait%0d_busy", i), AesBusyT, 1);
      end
      @(negedge clk); #1;
      checkVal("to_last_busy", AesBusyT, 1);
      checkVal("to_last_err",  AesErrT, 0);
      @(negedge clk); #1;
      checkVal("to_drain_busy", AesBusyT, 0);
      checkVal("to_drain_err",  AesErrT, 1);
      checkVal("to_drain_pcw",  PCWriteT, 1);
      @(negedge clk); AesReq = 0; #1;
      checkVal("to_idle_err", AesErrT, 1);
      @(negedge clk); AesReq = 1; #1;
      checkVal("to_req2_pcw", PCWriteT, 0);
      @(negedge clk); #1;
      checkVal("to_req2_go", AesGoT, 1);
      @(negedge clk); AesDone = 1; #1;
      checkVal("to_req2_busy", AesBusyT, 1);
      @(negedge clk); AesDone = 0; #1;
      checkVal("to_req2_drain", AesBusyT, 0);
      checkVal("to_sticky_err", AesErrT, 1);

      // Done in the timeout cycle wins; no error
      pulseReset();
      @(negedge clk); AesReq = 1; #1;
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); AesDone = 1; #1;
      checkVal("prec_busy", AesBusyT, 1);
      @(negedge clk); AesDone = 0; #1;
      checkVal("prec_drain", AesBusyT, 0);
      checkVal("prec_err",   AesErrT, 0);

      // AesReq held off by a load-use hazard, then reset mid-WAIT
      pulseReset();
      @(negedge clk); AesReq = 1; IdExMemRead = 1; IdExRegRt = 4; IfIdRegRs = 4; #1;
      checkVal("aeslu_pcw", PCWrite, 0);
      @(negedge clk); #1;
      checkVal("aeslu_go",   AesGo, 0);
      checkVal("aeslu_busy", AesBusy, 0);
      @(negedge clk); IdExMemRead = 0; IdExRegRt = 0; #1;
      checkVal("aeslu_clr_go", AesGo, 0);
      @(negedge clk); #1;
      checkVal("aeslu_issue_go", AesGo, 1);
      @(negedge clk); #1;
      checkVal("aeslu_wait_busy", AesBusy, 1);
      @(negedge clk); #1;
      #2 reset = 1'b1; AesReq = 0; #1;
      checkVal("midrst_busy",  AesBusy, 0);
      checkVal("midrst_go",    AesGo, 0);
      checkVal("midrst_pcw",   PCWrite, 1);
      checkVal("midrst_ifid",  IfIdWrite, 1);
      checkVal("midrst_flush", IdExFlush, 0);
      checkVal("midrst_cnt",   StallCycles, 0);
      @(negedge clk); reset = 0; AesDone = 1; #1;
      checkVal("latedone_busy", AesBusy, 0);
      @(negedge clk); AesDone = 0; AesReq = 1; #1;
      checkVal("latedone_idle_pcw", PCWrite, 0);
      checkVal("latedone_go",       AesGo, 0);
      @(negedge clk); #1;
      checkVal("latedone_issue_go", AesGo, 1);

      // StallCycles saturation
      @(negedge clk); clearIn(); reset = 1'b1;
      @(negedge clk); reset = 1'b0; IdExMemRead = 1; IdExRegRt = 3; IfIdRegRt = 3; #1;
      checkVal("sat_start", StallCycles, 0);
      repeat (65534) @(negedge clk);
      #1;
      checkVal("sat_fffe", StallCycles, 16'hFFFE);
      repeat (3) @(negedge clk);
      #1;
      checkVal("sat_ffff", StallCycles, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard and stall controller for the five-stage MIPS core with the attached AES coprocessor.
- Sits beside the operand forwarding unit. It detects hazards that forwarding cannot resolve:
  - load-use;
  - branch or jump-register operand not yet produced.
- It also sequences multi-cycle AES instructions through an issue/wait/drain FSM with a timeout.
- Drives the PC, IF/ID write enables and the ID/EX bubble insertion.

Parameters:
AES_TIMEOUT, 64, max WAIT cycles before abort; legal range 2..255
CNT_W, 8, width of WAIT counter; must satisfy 2^CNT_W > AES_TIMEOUT

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
IfIdRegRs  input  5  rs of instruction in ID
IfIdRegRt  input  5  rt of instruction in ID
IdExRegRt  input  5  rt of instruction in EX (load destination)
IdExRegDst  input  5  final destination register of instruction in EX
IdExMemRead  input  1  EX instruction is a load
IdExRegWrite  input  1  EX instruction writes a register
ExMemRegRd  input  5  destination of instruction in MEM
ExMemMemRead  input  1  MEM instruction is a load
Branch  input  1  ID instruction is beq/bne
JumpReg  input  1  ID instruction is jr/jalr
AesReq  input  1  ID instruction is an AES coprocessor op
AesDone  input  1  coprocessor completion pulse
PCWrite  output  1  1 = PC may update
IfIdWrite  output  1  1 = IF/ID may update
IdExFlush  output  1  1 = load bubble into ID/EX
AesGo  output  1  registered one-cycle start pulse to coprocessor
AesBusy  output  1  FSM in ISSUE or WAIT
AesErr  output  1  sticky timeout flag
StallCycles  output  16  saturating count of cycles with Stall=1

Behaviour:
- Reset (async, immediate):
  - state=IDLE, wait counter=0, AesGo=0, AesErr=0, StallCycles=0.
  - With inputs quiescent: PCWrite=1, IfIdWrite=1, IdExFlush=0, AesBusy=0.
- Combinational hazard terms; register 0 never matches:
  - LU (load-use): IdExMemRead && IdExRegRt!=0 && (IdExRegRt==IfIdRegRs || IdExRegRt==IfIdRegRt).
  - BR_EX: (Branch||JumpReg) && IdExRegWrite && IdExRegDst!=0 && match. Branch matches Rs or Rt; JumpReg matches Rs only.
  - BR_MEM: (Branch||JumpReg) && ExMemMemRead && ExMemRegRd!=0 && same match rule.
  - Effect: a branch after an ALU op stalls 1 cycle; a branch after a load stalls 2 cycles (BR_EX, then BR_MEM).
- Hz = LU | BR_EX | BR_MEM.
- Stall = Hz | (state==ISSUE) | (state==WAIT) | (state==IDLE && AesReq).
- Stall outputs:
  - PCWrite = ~Stall, IfIdWrite = ~Stall, IdExFlush = Stall.
  - All are combinational from inputs and state, with no added latency.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
  - IDLE: if AesReq && !Hz, go to ISSUE. If AesReq && Hz, stay in IDLE; operands must resolve before issue.
  - ISSUE (exactly 1 cycle): go to WAIT. AesGo=1 during the ISSUE cycle (registered, so it is high the cycle after IDLE->ISSUE is decided). Counter cleared to 0.
  - WAIT: counter increments each cycle.
    - AesDone=1: go to DRAIN.
    - Else counter==AES_TIMEOUT-1: go to DRAIN and set AesErr=1.
    - AesDone sampled in the same cycle as the timeout condition takes precedence; AesErr is not set.
  - DRAIN (1 cycle): no AES stall term, so the AES instruction leaves ID. AesReq is ignored during DRAIN, which prevents re-issue of the same instruction. Then go to IDLE.
  - AesDone outside WAIT is ignored.
- AesBusy = state in {ISSUE, WAIT}.
- AesErr clears only on reset.
- StallCycles increments on each cycle with Stall=1 and saturates at 16'hFFFF.
- Reset asserted mid-WAIT: returns to IDLE; AesGo stays 0. A later AesDone is ignored.

Test Plan:
- lw $5 in EX, ID add uses rs=5 -> one cycle PCWrite=0, IfIdWrite=0, IdExFlush=1, then all released; StallCycles=1.
- lw $0 in EX, ID uses rs=0 -> no stall, PCWrite=1 throughout.
- lw $7 then beq $7,$3 in ID -> stall 2 consecutive cycles (BR_EX, then BR_MEM), release on the 3rd; add $7 then jr $7 -> stall exactly 1 cycle.
- AesReq=1, no hazard, AesDone pulsed 5 cycles after AesGo -> AesGo high for 1 cycle, AesBusy high ISSUE..WAIT, one DRAIN cycle with PCWrite=1, then IDLE; AesErr=0.
- AES_TIMEOUT=4, AesDone never asserted -> DRAIN entered after 4 WAIT cycles, AesErr=1 sticky; second AesReq issues normally.
- AesReq with simultaneous LU hazard -> AesGo is not issued until the hazard clears. Reset asserted during WAIT -> outputs at reset values immediately; AesDone afterwards causes no transition.
